// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC generator and its BTB.
package fetch_pkg;

    // Widest PC the BTB entry fields can hold; narrower PCs are zero-extended.
    localparam int unsigned WORD_MAX  = 64;
    localparam int unsigned PC_INCR   = 4;
    localparam logic [1:0]  CTR_RESET = 2'b01;
    localparam logic [1:0]  CTR_ALLOC = 2'b10;

    typedef enum logic {
        BOOT,
        RUN
    } fetch_state_t;

    typedef struct packed {
        logic                valid;
        logic [WORD_MAX-1:0] tag;
        logic [WORD_MAX-1:0] target;
        logic [1:0]          ctr;
    } btb_entry_t;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Fetch-stage bus: redirect, BTB training, imem request and IF/ID outputs.
interface fetch_pc_gen_if #(
    parameter int unsigned WordSize = 32
);
    logic                stall;
    logic                flush;
    logic [WordSize-1:0] redirect_pc;
    logic                upd_valid;
    logic [WordSize-1:0] upd_pc;
    logic [WordSize-1:0] upd_target;
    logic                upd_taken;
    logic                imem_req_ready;
    logic                imem_req_valid;
    logic [WordSize-1:0] imem_addr;
    logic                if_valid;
    logic [WordSize-1:0] if_pc;
    logic                if_pred_taken;
    logic [WordSize-1:0] if_pred_pc;

    modport master (
        input  stall, flush, redirect_pc,
        input  upd_valid, upd_pc, upd_target, upd_taken,
        input  imem_req_ready,
        output imem_req_valid, imem_addr,
        output if_valid, if_pc, if_pred_taken, if_pred_pc
    );

    modport slave (
        output stall, flush, redirect_pc,
        output upd_valid, upd_pc, upd_target, upd_taken,
        output imem_req_ready,
        input  imem_req_valid, imem_addr,
        input  if_valid, if_pc, if_pred_taken, if_pred_pc
    );
endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
module fetch_btb
    import fetch_pkg::*;
#(
    parameter int unsigned WordSize   = 32,
    parameter int unsigned BtbEntries = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WordSize-1:0] lkp_pc_i,
    output logic                lkp_taken_o,
    output logic [WordSize-1:0] lkp_target_o,
    input  logic                upd_valid_i,
    input  logic [WordSize-1:0] upd_pc_i,
    input  logic [WordSize-1:0] upd_target_i,
    input  logic                upd_taken_i
);
    localparam int unsigned IW = $clog2(BtbEntries);

    btb_entry_t          entries_q [BtbEntries];
    btb_entry_t          lkp_entry;
    btb_entry_t          upd_entry;
    btb_entry_t          upd_entry_d;
    logic                upd_we;
    logic                upd_hit;
    logic [IW-1:0]       lkp_idx;
    logic [IW-1:0]       upd_idx;
    logic [WORD_MAX-1:0] lkp_tag;
    logic [WORD_MAX-1:0] upd_tag;

    assign lkp_idx = lkp_pc_i[2+IW-1:2];
    assign upd_idx = upd_pc_i[2+IW-1:2];
    assign lkp_tag = WORD_MAX'(lkp_pc_i >> (2 + IW));
    assign upd_tag = WORD_MAX'(upd_pc_i >> (2 + IW));

    // Lookup reads the registered array, so a same-cycle update is not yet visible.
    assign lkp_entry    = entries_q[lkp_idx];
    assign lkp_taken_o  = lkp_entry.valid && (lkp_entry.tag == lkp_tag) && lkp_entry.ctr[1];
    assign lkp_target_o = WordSize'(lkp_entry.target);

    assign upd_entry = entries_q[upd_idx];
    assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        upd_we      = 1'b0;
        upd_entry_d = upd_entry;
        if (upd_valid_i) begin
            if (upd_hit) begin
                upd_we          = 1'b1;
                upd_entry_d.ctr = ctr_step(upd_entry.ctr, upd_taken_i);
                if (upd_taken_i) begin
                    upd_entry_d.target = WORD_MAX'(upd_target_i);
                end
            end else if (upd_taken_i) begin
                upd_we      = 1'b1;
                upd_entry_d = '{valid: 1'b1, tag: upd_tag,
                                target: WORD_MAX'(upd_target_i), ctr: CTR_ALLOC};
            end
        end
    end

    // NOTE: the array is reset entry by entry because stale valid bits would mispredict.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BtbEntries); i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
            end
        end else if (upd_we) begin
            entries_q[upd_idx] <= upd_entry_d;
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator: PC register, imem request and IF/ID register.
// Define FETCH_BTB_EN to add the BTB branch predictor; otherwise pc+4 is predicted.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned         WordSize    = 32,
    parameter int unsigned         BtbEntries  = 8,
    parameter logic [WordSize-1:0] ResetVector = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_gen_if.master bus
);
    fetch_state_t        state_q, state_d;
    logic [WordSize-1:0] pc_q, pc_d;
    logic [WordSize-1:0] pc_seq;
    logic [WordSize-1:0] pred_pc;
    logic                pred_taken;
    logic                req_valid;
    logic                accept;
    logic                if_valid_q, if_valid_d;
    logic [WordSize-1:0] if_pc_q, if_pc_d;
    logic                if_pred_taken_q, if_pred_taken_d;
    logic [WordSize-1:0] if_pred_pc_q, if_pred_pc_d;

    assign pc_seq = pc_q + WordSize'(PC_INCR);

`ifdef FETCH_BTB_EN
    logic                btb_taken;
    logic [WordSize-1:0] btb_target;

    fetch_btb #(
        .WordSize   (WordSize),
        .BtbEntries (BtbEntries)
    ) u_btb (
        .clk          (clk),
        .rst          (rst),
        .lkp_pc_i     (pc_q),
        .lkp_taken_o  (btb_taken),
        .lkp_target_o (btb_target),
        .upd_valid_i  (bus.upd_valid),
        .upd_pc_i     (bus.upd_pc),
        .upd_target_i (bus.upd_target),
        .upd_taken_i  (bus.upd_taken)
    );

    assign pred_taken = btb_taken;
    assign pred_pc    = btb_taken ? btb_target : pc_seq;
`else
    logic unused_upd;
    assign unused_upd = ^{bus.upd_valid, bus.upd_pc, bus.upd_target, bus.upd_taken};
    assign pred_taken = 1'b0;
    assign pred_pc    = pc_seq;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN:  state_d = RUN;
        endcase
    end

    // Flush beats stall, stall beats accept; a flushed cycle never issues a request.
    always_comb begin
        req_valid       = (state_q == RUN) && !bus.stall && !bus.flush;
        accept          = req_valid && bus.imem_req_ready;
        pc_d            = pc_q;
        if_valid_d      = if_valid_q;
        if_pc_d         = if_pc_q;
        if_pred_taken_d = if_pred_taken_q;
        if_pred_pc_d    = if_pred_pc_q;
        if (bus.flush) begin
            pc_d       = {bus.redirect_pc[WordSize-1:2], 2'b00};
            if_valid_d = 1'b0;
        end else if (!bus.stall) begin
            if (accept) begin
                pc_d            = pred_pc;
                if_valid_d      = 1'b1;
                if_pc_d         = pc_q;
                if_pred_taken_d = pred_taken;
                if_pred_pc_d    = pred_pc;
            end else begin
                if_valid_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= BOOT;
            pc_q            <= ResetVector;
            if_valid_q      <= 1'b0;
            if_pc_q         <= '0;
            if_pred_taken_q <= 1'b0;
            if_pred_pc_q    <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            if_valid_q      <= if_valid_d;
            if_pc_q         <= if_pc_d;
            if_pred_taken_q <= if_pred_taken_d;
            if_pred_pc_q    <= if_pred_pc_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_pred_taken  = if_pred_taken_q;
    assign bus.if_pred_pc     = if_pred_pc_q;

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen: per-cycle model compare plus directed literal checks.
module tb_fetch_pc_gen;

    localparam int unsigned BTB_N     = 8;
    localparam logic [31:0] RESET_VEC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    fetch_pc_gen_if #(.WordSize(32)) bus ();

    fetch_pc_gen #(
        .WordSize    (32),
        .BtbEntries  (BTB_N),
        .ResetVector (RESET_VEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          m_known = 1'b0;
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_ifv;
    logic [31:0] m_ifpc;
    bit          m_ift;
    logic [31:0] m_ifp;
    bit          mb_valid  [BTB_N];
    int unsigned mb_tag    [BTB_N];
    logic [31:0] mb_target [BTB_N];
    int          mb_ctr    [BTB_N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void predict(input logic [31:0] pc, output bit taken, output logic [31:0] nxt);
        int unsigned idx;
        idx   = (pc >> 2) % BTB_N;
        taken = 1'b0;
        nxt   = pc + 32'd4;
`ifdef FETCH_BTB_EN
        if (mb_valid[idx] && mb_tag[idx] == pc / (4 * BTB_N) && mb_ctr[idx] >= 2) begin
            taken = 1'b1;
            nxt   = mb_target[idx];
        end
`endif
    endfunction

    always @(posedge clk) begin : model
        bit          tk;
        logic [31:0] nx;
        bit          acc;
        int unsigned ui;
        if (rst) begin
            m_known <= 1'b1;
            m_boot  <= 1'b1;
            m_pc    <= RESET_VEC;
            m_ifv   <= 1'b0;
            m_ifpc  <= '0;
            m_ift   <= 1'b0;
            m_ifp   <= '0;
            for (int i = 0; i < BTB_N; i++) begin
                mb_valid[i] <= 1'b0;
                mb_ctr[i]   <= 1;
            end
        end else begin
            predict(m_pc, tk, nx);
            acc = !m_boot && !bus.stall && !bus.flush && bus.imem_req_ready;
            m_boot <= 1'b0;
            if (bus.flush) begin
                m_pc  <= bus.redirect_pc & ~32'h3;
                m_ifv <= 1'b0;
            end else if (!bus.stall) begin
                if (acc) begin
                    m_ifv  <= 1'b1;
                    m_ifpc <= m_pc;
                    m_ift  <= tk;
                    m_ifp  <= nx;
                    m_pc   <= nx;
                end else begin
                    m_ifv <= 1'b0;
                end
            end
            if (bus.upd_valid) begin
                ui = (bus.upd_pc >> 2) % BTB_N;
                if (mb_valid[ui] && mb_tag[ui] == bus.upd_pc / (4 * BTB_N)) begin
                    if (bus.upd_taken) begin
                        mb_ctr[ui]    <= (mb_ctr[ui] < 3) ? mb_ctr[ui] + 1 : 3;
                        mb_target[ui] <= bus.upd_target;
                    end else begin
                        mb_ctr[ui] <= (mb_ctr[ui] > 0) ? mb_ctr[ui] - 1 : 0;
                    end
                end else if (bus.upd_taken) begin
                    mb_valid[ui]  <= 1'b1;
                    mb_tag[ui]    <= bus.upd_pc / (4 * BTB_N);
                    mb_target[ui] <= bus.upd_target;
                    mb_ctr[ui]    <= 2;
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen reset
    always @(negedge clk) begin
        if (m_known) begin
            check("req_valid", 64'(bus.imem_req_valid), 64'(!m_boot && !bus.stall && !bus.flush));
            check("imem_addr", 64'(bus.imem_addr), 64'(m_pc));
            check("if_valid", 64'(bus.if_valid), 64'(m_ifv));
            check("if_pc", 64'(bus.if_pc), 64'(m_ifpc));
            check("if_pred_taken", 64'(bus.if_pred_taken), 64'(m_ift));
            check("if_pred_pc", 64'(bus.if_pred_pc), 64'(m_ifp));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        bus.flush       = 1'b1;
        bus.redirect_pc = pc;
        tick();
        bus.flush       = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input bit taken, input int n);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = taken;
        tick(n);
        bus.upd_valid  = 1'b0;
    endtask

    initial begin
        rst                = 1'b1;
        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_pc    = '0;
        bus.upd_valid      = 1'b0;
        bus.upd_pc         = '0;
        bus.upd_target     = '0;
        bus.upd_taken      = 1'b0;
        bus.imem_req_ready = 1'b1;

        // Reset values
        tick(2);
        check("rst_addr", 64'(bus.imem_addr), 64'h0);
        check("rst_req", 64'(bus.imem_req_valid), 64'h0);
        check("rst_if_valid", 64'(bus.if_valid), 64'h0);
        check("rst_if_pred_pc", 64'(bus.if_pred_pc), 64'h0);
        rst = 1'b0;

        // BOOT cycle, then sequential fetch 0x0, 0x4, 0x8
        tick();
        check("boot_req", 64'(bus.imem_req_valid), 64'h1);
        check("first_addr", 64'(bus.imem_addr), 64'h0);
        tick();
        check("addr_4", 64'(bus.imem_addr), 64'h4);
        check("if_valid_rise", 64'(bus.if_valid), 64'h1);
        check("if_pc_0", 64'(bus.if_pc), 64'h0);
        tick();
        check("addr_8", 64'(bus.imem_addr), 64'h8);

        // Memory not ready for three cycles at 0x10
        tick(2);
        check("addr_10", 64'(bus.imem_addr), 64'h10);
        bus.imem_req_ready = 1'b0;
        tick();
        check("hold_addr", 64'(bus.imem_addr), 64'h10);
        check("hold_if_valid", 64'(bus.if_valid), 64'h0);
        tick(2);
        check("hold_addr3", 64'(bus.imem_addr), 64'h10);
        bus.imem_req_ready = 1'b1;
        tick();
        check("resume_addr", 64'(bus.imem_addr), 64'h14);
        check("resume_if_pc", 64'(bus.if_pc), 64'h10);

        // Flush with unaligned redirect while at 0x20
        tick(3);
        check("addr_20", 64'(bus.imem_addr), 64'h20);
        redirect(32'h203);
        check("redir_addr", 64'(bus.imem_addr), 64'h200);
        check("redir_if_valid", 64'(bus.if_valid), 64'h0);

        // Stall holds, then stall+flush takes the redirect
        tick();
        check("addr_204", 64'(bus.imem_addr), 64'h204);
        bus.stall = 1'b1;
        tick();
        check("stall_addr", 64'(bus.imem_addr), 64'h204);
        check("stall_if_valid", 64'(bus.if_valid), 64'h1);
        check("stall_if_pc", 64'(bus.if_pc), 64'h200);
        redirect(32'h300);
        bus.stall = 1'b0;
        check("stall_flush_addr", 64'(bus.imem_addr), 64'h300);
        check("stall_flush_if_valid", 64'(bus.if_valid), 64'h0);

        // One taken update allocates the entry for 0x40
        train(32'h40, 32'h100, 1'b1, 1);
        redirect(32'h40);
        tick();
`ifdef FETCH_BTB_EN
        check("btb_taken_addr", 64'(bus.imem_addr), 64'h100);
        check("btb_pred_taken", 64'(bus.if_pred_taken), 64'h1);
        check("btb_pred_pc", 64'(bus.if_pred_pc), 64'h100);
`else
        check("nobtb_addr", 64'(bus.imem_addr), 64'h44);
        check("nobtb_pred_taken", 64'(bus.if_pred_taken), 64'h0);
        check("nobtb_pred_pc", 64'(bus.if_pred_pc), 64'h44);
`endif

        // Two not-taken updates drop the counter below taken
        train(32'h40, 32'h100, 1'b0, 2);
        redirect(32'h40);
        tick();
        check("nt_addr", 64'(bus.imem_addr), 64'h44);
        check("nt_pred_taken", 64'(bus.if_pred_taken), 64'h0);

        // Saturation: five taken then one not-taken stays taken
        train(32'h40, 32'h100, 1'b1, 5);
        train(32'h40, 32'h100, 1'b0, 1);
        redirect(32'h40);
        // Same-cycle not-taken update: lookup still sees the counter at 2
        train(32'h40, 32'h100, 1'b0, 1);
`ifdef FETCH_BTB_EN
        check("sat_addr", 64'(bus.imem_addr), 64'h100);
`else
        check("sat_addr", 64'(bus.imem_addr), 64'h44);
`endif
        redirect(32'h40);
        tick();
        check("post_upd_addr", 64'(bus.imem_addr), 64'h44);

        // Same index, different tag misses
        redirect(32'h60);
        tick();
        check("alias_addr", 64'(bus.imem_addr), 64'h64);

        // Retrain, then reset mid-run clears the BTB
        train(32'h40, 32'h100, 1'b1, 1);
        rst = 1'b1;
        tick();
        check("midrst_addr", 64'(bus.imem_addr), 64'h0);
        check("midrst_if_valid", 64'(bus.if_valid), 64'h0);
        check("midrst_if_pc", 64'(bus.if_pc), 64'h0);
        rst = 1'b0;
        tick();
        check("midrst_run_req", 64'(bus.imem_req_valid), 64'h1);
        redirect(32'h40);
        tick();
        check("cleared_addr", 64'(bus.imem_addr), 64'h44);
        check("cleared_pred", 64'(bus.if_pred_taken), 64'h0);

        // Mixed traffic checked by the model alone
        for (int i = 0; i < 60; i++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            bus.stall          = ($urandom_range(0, 7) == 0);
            bus.flush          = ($urandom_range(0, 11) == 0);
            bus.redirect_pc    = 32'h40 + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            bus.upd_valid      = ($urandom_range(0, 2) == 0);
            bus.upd_pc         = 32'h40 + 32'($urandom_range(0, 15)) * 4;
            bus.upd_target     = 32'h40 + 32'($urandom_range(0, 15)) * 4;
            bus.upd_taken      = ($urandom_range(0, 2) != 0);
            tick();
        end
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.upd_valid = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
